// File: rtl/decoder_stage_controller.sv
// Global stage sequencer for the decoder PU array: walks LOAD -> MERGE/GROW rounds -> PEELING -> RESULT,
// broadcasting the current stage and tracking grow rounds and active cycles.
module decoder_stage_controller #(
  parameter int PU_COUNT    = 8,
  parameter int MAX_GROW    = 15,
  parameter int SETTLE      = 3,
  parameter int STAGE_WIDTH = 3
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  output logic                   start_ready,
  output logic [STAGE_WIDTH-1:0] global_stage,
  input  logic [PU_COUNT-1:0]    pu_busy,
  input  logic [PU_COUNT-1:0]    pu_odd,
  output logic                   result_valid,
  input  logic                   result_ready,
  output logic                   result_error,
  output logic [3:0]             grow_count,
  output logic [15:0]            cycle_count
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_GROW   = 3'd2,
    S_MERGE  = 3'd3,
    S_PEEL   = 3'd4,
    S_RESULT = 3'd5
  } stage_e;

  localparam int DWELL_W = $clog2(SETTLE + 2);

  stage_e               state_q, state_d;
  logic [DWELL_W-1:0]   dwell_q, dwell_d;
  logic [3:0]           grow_q, grow_d;
  logic [15:0]          cyc_q, cyc_d;
  logic                 err_q, err_d;
  logic                 settled;
  logic                 any_busy;
  logic                 any_odd;

  // dwell_q counts cycles already spent in the state, so the current cycle is dwell_q+1;
  // this covers the PU's one-cycle stage lag plus its one-cycle busy lag.
  assign settled  = (int'(dwell_q) + 1) >= SETTLE;
  assign any_busy = |pu_busy;
  assign any_odd  = |pu_odd;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      dwell_q <= '0;
      grow_q  <= '0;
      cyc_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      dwell_q <= dwell_d;
      grow_q  <= grow_d;
      cyc_q   <= cyc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    grow_d  = grow_q;
    err_d   = err_q;
    dwell_d = (dwell_q != '1) ? dwell_q + 1'b1 : dwell_q;
    cyc_d   = cyc_q;
    if (state_q != S_IDLE && state_q != S_RESULT && cyc_q != 16'hFFFF)
      cyc_d = cyc_q + 16'd1;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          grow_d  = '0;
          cyc_d   = '0;
          err_d   = 1'b0;
        end
      end
      S_LOAD: begin
        if (dwell_q == DWELL_W'(1)) state_d = S_MERGE;
      end
      S_GROW: begin
        if (dwell_q == DWELL_W'(1)) state_d = S_MERGE;
      end
      S_MERGE: begin
        if (settled && !any_busy) begin
          if (!any_odd) begin
            state_d = S_PEEL;
          end else if (grow_q == 4'(MAX_GROW)) begin
            state_d = S_RESULT;
            err_d   = 1'b1;
          end else begin
            state_d = S_GROW;
            grow_d  = grow_q + 4'd1;
          end
        end
      end
      S_PEEL: begin
        if (settled && !any_busy) state_d = S_RESULT;
      end
      S_RESULT: begin
        // start is deliberately not looked at here; a new decode needs a visit to IDLE
        if (result_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    if (state_d != state_q) dwell_d = '0;
  end

  assign global_stage = STAGE_WIDTH'(state_q);
  assign start_ready  = (state_q == S_IDLE);
  assign result_valid = (state_q == S_RESULT);
  assign result_error = err_q;
  assign grow_count   = grow_q;
  assign cycle_count  = cyc_q;

endmodule
